// File: rtl/pipe_pkg.sv
// Shared definitions for the pipelined CPU datapath registers.
// Holds default widths, control-bundle bit positions, the EX/MEM payload layout and the buffer occupancy states.
package pipe_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_REG_ADDR_W = 3;
    localparam int DEF_WB_W       = 2;
    localparam int DEF_MEM_W      = 2;

    localparam int WB_REGWRITE = 1;
    localparam int MEM_READ    = 1;
    localparam int MEM_WRITE   = 0;

    // Buffer state encodes the number of held entries directly
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    typedef struct packed {
        logic [DEF_WB_W-1:0]       wb;
        logic [DEF_MEM_W-1:0]      mem;
        logic [DEF_DATA_W-1:0]     fu_result;
        logic [DEF_DATA_W-1:0]     rt_data;
        logic [DEF_REG_ADDR_W-1:0] write_dst;
    } ex_mem_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer with synchronous flush and a registered in_ready_o.
// Vacated entries are cleared so stale payload never lingers in the datapath.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   occupancy_o
);

    occ_state_e   state_reg;
    logic [W-1:0] main_reg;
    logic [W-1:0] skid_reg;
    logic         in_ready_reg;
    logic         in_fire;
    logic         out_fire;

    assign in_fire  = in_valid_i & in_ready_reg;
    assign out_fire = (state_reg != OCC_EMPTY) & out_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n || flush_i) begin
            state_reg    <= OCC_EMPTY;
            main_reg     <= '0;
            skid_reg     <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            unique case (state_reg)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        main_reg  <= in_data_i;
                        state_reg <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        main_reg <= in_data_i;
                    end else if (out_fire) begin
                        main_reg  <= '0;
                        state_reg <= OCC_EMPTY;
                    end else if (in_fire) begin
                        // Head is stalled: park the new instruction behind it
                        skid_reg     <= in_data_i;
                        state_reg    <= OCC_FULL;
                        in_ready_reg <= 1'b0;
                    end
                end
                OCC_FULL: begin
                    if (out_fire) begin
                        main_reg     <= skid_reg;
                        skid_reg     <= '0;
                        state_reg    <= OCC_ONE;
                        in_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg    <= OCC_EMPTY;
                    main_reg     <= '0;
                    skid_reg     <= '0;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_reg;
    assign out_valid_o = (state_reg != OCC_EMPTY);
    assign out_data_o  = main_reg;
    assign occupancy_o = state_reg;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with valid/ready handshake, optional skid entry, flush and bubble zeroing.
// fwd_valid_o tells the forwarding unit that the held instruction will write a register.
module ex_mem_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int WB_W       = DEF_WB_W,
    parameter int MEM_W      = DEF_MEM_W,
    parameter int SKID       = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WB_W-1:0]       wb_i,
    input  logic [MEM_W-1:0]      mem_i,
    input  logic [DATA_W-1:0]     fu_result_i,
    input  logic [DATA_W-1:0]     rt_data_i,
    input  logic [REG_ADDR_W-1:0] write_dst_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WB_W-1:0]       wb_o,
    output logic [MEM_W-1:0]      mem_o,
    output logic [DATA_W-1:0]     fu_result_o,
    output logic [DATA_W-1:0]     rt_data_o,
    output logic [REG_ADDR_W-1:0] write_dst_o,
    output logic                  fwd_valid_o,
    output logic [1:0]            occupancy_o
);

    localparam int PW = WB_W + MEM_W + 2 * DATA_W + REG_ADDR_W;

    logic [PW-1:0] in_data;
    logic [PW-1:0] head_data;
    logic [PW-1:0] out_data;
    logic          head_valid;

    assign in_data = {wb_i, mem_i, fu_result_i, rt_data_i, write_dst_i};

    generate
        if (SKID != 0) begin : g_skid
            pipe_skid_buf #(.W(PW)) u_buf (
                .clk_i       (clk_i),
                .rst_n       (rst_n),
                .flush_i     (flush_i),
                .in_valid_i  (in_valid_i),
                .in_ready_o  (in_ready_o),
                .in_data_i   (in_data),
                .out_valid_o (head_valid),
                .out_ready_i (out_ready_i),
                .out_data_o  (head_data),
                .occupancy_o (occupancy_o)
            );
        end else begin : g_single
            logic          valid_reg;
            logic [PW-1:0] main_reg;
            logic          in_fire;
            logic          out_fire;

            // Single entry can accept in the same cycle its occupant leaves
            assign in_ready_o = ~valid_reg | out_ready_i;
            assign in_fire    = in_valid_i & in_ready_o;
            assign out_fire   = valid_reg & out_ready_i;

            always_ff @(posedge clk_i) begin
                if (!rst_n || flush_i) begin
                    valid_reg <= 1'b0;
                    main_reg  <= '0;
                end else if (in_fire) begin
                    valid_reg <= 1'b1;
                    main_reg  <= in_data;
                end else if (out_fire) begin
                    valid_reg <= 1'b0;
                    main_reg  <= '0;
                end
            end

            assign head_valid  = valid_reg;
            assign head_data   = main_reg;
            assign occupancy_o = {1'b0, valid_reg};
        end
    endgenerate

    // Bubbles must present all-zero control so MEM/WB take no action
    generate
        for (genvar gi = 0; gi < PW; gi++) begin : g_bubble
            assign out_data[gi] = head_data[gi] & head_valid;
        end
    endgenerate

    assign {wb_o, mem_o, fu_result_o, rt_data_o, write_dst_o} = out_data;
    assign out_valid_o = head_valid;
    assign fwd_valid_o = head_valid & wb_o[WB_REGWRITE];

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench driving a SKID=1 and a SKID=0 instance with identical stimulus.
// Each instance has its own queue model of held instructions; a negedge monitor compares every cycle.
module tb_ex_mem_pipe_reg;
    import pipe_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush_i = 1'b0;
    logic       in_valid_i = 1'b0;
    logic [1:0] wb_i = '0;
    logic [1:0] mem_i = '0;
    logic [15:0] fu_result_i = '0;
    logic [15:0] rt_data_i = '0;
    logic [2:0] write_dst_i = '0;
    logic       out_ready_i = 1'b0;

    logic        a_in_ready, a_out_valid, a_fwd;
    logic [1:0]  a_wb, a_mem, a_occ;
    logic [15:0] a_fu, a_rt;
    logic [2:0]  a_dst;
    logic        b_in_ready, b_out_valid, b_fwd;
    logic [1:0]  b_wb, b_mem, b_occ;
    logic [15:0] b_fu, b_rt;
    logic [2:0]  b_dst;

    always #5 clk_i = ~clk_i;

    ex_mem_pipe_reg #(.SKID(1)) dut_a (
        .clk_i(clk_i), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(a_in_ready),
        .wb_i(wb_i), .mem_i(mem_i), .fu_result_i(fu_result_i),
        .rt_data_i(rt_data_i), .write_dst_i(write_dst_i),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready_i),
        .wb_o(a_wb), .mem_o(a_mem), .fu_result_o(a_fu),
        .rt_data_o(a_rt), .write_dst_o(a_dst),
        .fwd_valid_o(a_fwd), .occupancy_o(a_occ)
    );

    ex_mem_pipe_reg #(.SKID(0)) dut_b (
        .clk_i(clk_i), .rst_n(rst_n), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(b_in_ready),
        .wb_i(wb_i), .mem_i(mem_i), .fu_result_i(fu_result_i),
        .rt_data_i(rt_data_i), .write_dst_i(write_dst_i),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready_i),
        .wb_o(b_wb), .mem_o(b_mem), .fu_result_o(b_fu),
        .rt_data_o(b_rt), .write_dst_o(b_dst),
        .fwd_valid_o(b_fwd), .occupancy_o(b_occ)
    );

    ex_mem_payload_t qa[$];
    ex_mem_payload_t qb[$];
    int  n_checks = 0;
    int  n_fail = 0;
    bit  started = 1'b0;

    task automatic check_one(input string nm, input bit skid, input logic in_rdy,
                             input logic ov, input logic [1:0] occ, input logic fwd,
                             input ex_mem_payload_t act, input int qsz,
                             input ex_mem_payload_t head, input logic o_rdy);
        logic            exp_rdy;
        logic            exp_valid;
        ex_mem_payload_t exp_pl;
        logic            exp_fwd;
        exp_rdy   = skid ? (qsz < 2) : (qsz == 0 || o_rdy);
        exp_valid = (qsz > 0);
        exp_pl    = exp_valid ? head : '0;
        exp_fwd   = exp_valid && head.wb[WB_REGWRITE];

        n_checks++;
        if (occ !== 2'(qsz)) begin
            n_fail++;
            $display("FAIL %s occupancy: got %0d expected %0d at %0t", nm, occ, qsz, $time);
        end
        n_checks++;
        if (in_rdy !== exp_rdy) begin
            n_fail++;
            $display("FAIL %s in_ready: got %b expected %b at %0t", nm, in_rdy, exp_rdy, $time);
        end
        n_checks++;
        if (ov !== exp_valid) begin
            n_fail++;
            $display("FAIL %s out_valid: got %b expected %b at %0t", nm, ov, exp_valid, $time);
        end
        n_checks++;
        if (act !== exp_pl) begin
            n_fail++;
            $display("FAIL %s payload: got %h expected %h at %0t", nm, act, exp_pl, $time);
        end
        n_checks++;
        if (fwd !== exp_fwd) begin
            n_fail++;
            $display("FAIL %s fwd_valid: got %b expected %b at %0t", nm, fwd, exp_fwd, $time);
        end
    endtask

    // Monitor: compare current DUT state, then advance each model over the coming edge
    always @(negedge clk_i) begin
        ex_mem_payload_t cur, ha, hb, act_a, act_b;
        bit a_rdy_m, b_rdy_m;
        if (started) begin
            ha    = (qa.size() > 0) ? qa[0] : '0;
            hb    = (qb.size() > 0) ? qb[0] : '0;
            act_a = '{wb: a_wb, mem: a_mem, fu_result: a_fu, rt_data: a_rt, write_dst: a_dst};
            act_b = '{wb: b_wb, mem: b_mem, fu_result: b_fu, rt_data: b_rt, write_dst: b_dst};
            check_one("A", 1'b1, a_in_ready, a_out_valid, a_occ, a_fwd, act_a, qa.size(), ha, out_ready_i);
            check_one("B", 1'b0, b_in_ready, b_out_valid, b_occ, b_fwd, act_b, qb.size(), hb, out_ready_i);

            cur = '{wb: wb_i, mem: mem_i, fu_result: fu_result_i, rt_data: rt_data_i, write_dst: write_dst_i};
            if (!rst_n || flush_i) begin
                qa.delete();
                qb.delete();
            end else begin
                a_rdy_m = (qa.size() < 2);
                b_rdy_m = (qb.size() == 0) || out_ready_i;
                if (qa.size() > 0 && out_ready_i) begin
                    $display("A out fu=%h rt=%h dst=%0d wb=%b mem=%b", ha.fu_result, ha.rt_data, ha.write_dst, ha.wb, ha.mem);
                    void'(qa.pop_front());
                end
                if (in_valid_i && a_rdy_m) qa.push_back(cur);
                if (qb.size() > 0 && out_ready_i) begin
                    $display("B out fu=%h rt=%h dst=%0d wb=%b mem=%b", hb.fu_result, hb.rt_data, hb.write_dst, hb.wb, hb.mem);
                    void'(qb.pop_front());
                end
                if (in_valid_i && b_rdy_m) qb.push_back(cur);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] fu, input logic [1:0] wb);
        in_valid_i  = v;
        fu_result_i = fu;
        wb_i        = wb;
        mem_i       = 2'($urandom_range(0, 3));
        rt_data_i   = 16'($urandom);
        write_dst_i = 3'($urandom_range(0, 7));
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        step();
        started = 1'b1;
        step();
        rst_n = 1'b1;

        // Streaming at full rate
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'h0011 + 16'(i), 2'b10);
            step();
        end
        in_valid_i = 1'b0;
        step();
        step();

        // Backpressure into the skid entry, then drain
        out_ready_i = 1'b0;
        drive(1'b1, 16'hAAAA, 2'b10);
        step();
        drive(1'b1, 16'hBBBB, 2'b01);
        step();
        in_valid_i = 1'b0;
        step();
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // Flush while full, with an input offered on the flush edge
        out_ready_i = 1'b0;
        drive(1'b1, 16'hAAAA, 2'b10);
        step();
        drive(1'b1, 16'hBBBB, 2'b10);
        step();
        drive(1'b1, 16'hCCCC, 2'b10);
        flush_i = 1'b1;
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        step();

        // Bubble with live-looking control on the inputs
        in_valid_i = 1'b0;
        wb_i       = 2'b11;
        mem_i      = 2'b01;
        step();
        step();

        // Reset mid-stream, then single-entry backpressure
        out_ready_i = 1'b0;
        drive(1'b1, 16'h1234, 2'b10);
        step();
        in_valid_i = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(1'b1, 16'h5678, 2'b10);
        step();
        drive(1'b1, 16'h9ABC, 2'b10);
        step();
        out_ready_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        step();
        step();

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom), 2'($urandom_range(0, 3)));
            out_ready_i = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 24) == 0);
            rst_n       = ($urandom_range(0, 79) != 0);
            step();
        end
        flush_i     = 1'b0;
        rst_n       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) step();

        @(negedge clk_i);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
